mem_fill_arbiter: RTL and testbench
===================================

Name: mem_fill_arbiter

Overview:
- Parametrised successor to the two-cache miss/memory glue.
- Arbitrates block-fill requests from NUM_PORTS caches (e.g. port 0 = D-cache, port 1 = I-cache) and write-through stores onto one shared pipelined memory port.
- Streams each fill block into the granted cache's data array, then writes its tag.
- Adds selectable fixed or round-robin priority and a parametrised block size.

Parameters:
NUM_PORTS, 2, number of fill requesters (>=1)
AW, 16, byte address width
DW, 16, data word width
BLOCK_WORDS, 8, words per cache block (power of 2, >=2)
PRIO_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
miss_req  in  NUM_PORTS  per-port fill request, level, held until the tag is written
miss_addr  in  NUM_PORTS*AW  per-port miss address, port i in bits [i*AW +: AW]
grant  out  NUM_PORTS  one-hot, port currently being filled
fill_we  out  NUM_PORTS  data-array write strobe for the granted port
fill_tag_we  out  NUM_PORTS  tag-array write strobe for the granted port
fill_addr  out  AW  address of the word being written
fill_data  out  DW  word being written (mem_rdata passthrough)
busy  out  1  high in every state except IDLE
wr_req  in  1  write-through request
wr_addr  in  AW  write-through address
wr_data  in  DW  write-through data
wr_ack  out  1  one-cycle pulse, write issued this cycle
mem_en  out  1  memory request
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
mem_rvalid  in  1  read data valid, fixed latency, in issue order

Behaviour:
- Reset (async on rst_n low):
  - state IDLE; issue and receive counters 0; round-robin pointer 0.
  - All outputs 0.
  - Reset mid-fill abandons the fill; no partial tag write.
- Word address: OFF = log2(BLOCK_WORDS*DW/8); base = miss_addr with low OFF bits cleared; word k at base + k*(DW/8).
- States: IDLE, FILL.
- IDLE, checked in this order:
  - wr_req=1: mem_en=1, mem_wr=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1 combinationally; stay IDLE. Writes beat fills, so a later fill reads updated memory.
  - Else any miss_req bit set: pick the winner, register grant and base, go to FILL.
    - Fixed mode: lowest index wins.
    - RR mode: first requester at or after the pointer wins, wrapping modulo NUM_PORTS; pointer becomes winner+1 mod NUM_PORTS.
  - Else stay IDLE.
- FILL, issue side:
  - While iss_cnt < BLOCK_WORDS: mem_en=1, mem_wr=0, mem_addr=word(iss_cnt), iss_cnt++ each cycle.
  - One issue per cycle, no gaps.
- FILL, receive side:
  - Each cycle mem_rvalid=1: fill_we[granted]=1, fill_addr=word(rcv_cnt), fill_data=mem_rdata, rcv_cnt++.
  - Issue and receive overlap.
- Completion:
  - On the rvalid with rcv_cnt = BLOCK_WORDS-1: fill_tag_we[granted]=1 in the same cycle as that final data write.
  - Next cycle: IDLE, grant=0, counters 0. Arbitration may grant again that cycle, giving back-to-back fills.
- wr_req during FILL: wr_ack=0; request waits, must be held, and is served in IDLE.
- No preemption. A granted fill always completes even if that port's miss_req drops; lower-priority requests wait.
- mem_rvalid in IDLE, or beyond BLOCK_WORDS in one fill: ignored, no strobes.
- Counters are log2(BLOCK_WORDS)+1 bits; no wrap within a fill.
- busy=1 in FILL only; a one-cycle write-through does not assert busy.

Decomposition:
- Shared package: state encoding (ST_IDLE, ST_FILL); PRIO_FIXED=0, PRIO_RR=1; clog2 helper for OFF and counter widths.
- One sub-module, fill_arbiter: request vector + PRIO_MODE + pointer -> one-hot winner; owns the RR pointer register (clk, rst_n).
- Top level holds the FSM, counters, base register and memory muxing.

Test Plan:
- Single fill, port 1, miss_addr=0x1234, memory latency 4, BLOCK_WORDS=8 -> mem_addr 0x1230..0x123E on 8 consecutive cycles; fill_we[1] on 8 rvalids with fill_addr 0x1230..0x123E; fill_tag_we[1] with the last word; busy drops next cycle.
- miss_req=2'b11 in the same cycle, fixed mode -> port 0 filled first; port 1 granted on the cycle IDLE is re-entered; no lost or duplicated words.
- RR mode, both ports requesting continuously for 4 fills -> grant order 0,1,0,1.
- wr_req with miss_req[0] in IDLE -> wr_ack that cycle (mem_wr=1, wr_addr/wr_data on the bus), fill starts next cycle. wr_req held during FILL -> wr_ack=0 until IDLE, then issued once.
- rst_n low after 3 of 8 words received -> all outputs 0 immediately; late rvalids cause no fill_we or fill_tag_we; a new request fills cleanly.
- Spurious mem_rvalid in IDLE -> no strobes, state unchanged.

Source files
------------

// File: rtl/mem_fill_arbiter_pkg.sv
// Shared definitions for the cache-fill arbiter.
//   state_t     : FSM encoding (ST_IDLE, ST_FILL)
//   PRIO_FIXED  : lowest-index requester wins
//   PRIO_RR     : round-robin starting at the rotating pointer
//   clog2()     : elaboration-time ceiling log2 for offset and counter widths
package mem_fill_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_fill_arbiter_arb.sv
// Request arbiter for the fill engine.
//   clk, rst_n : clock and asynchronous active-low reset (pointer register only)
//   req        : per-port fill request vector
//   take       : the FSM accepts the current winner this cycle
//   win        : one-hot winner (all zero when nothing requests)
// Fixed mode picks the lowest index. Round-robin mode searches from the
// pointer upwards, wrapping, and moves the pointer past each accepted winner.
module fill_arbiter
    import mem_fill_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PRIO_MODE = PRIO_FIXED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 take,
    output logic [NUM_PORTS-1:0] win
);

    localparam int PW = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;

    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (PRIO_MODE == PRIO_RR) idx = PW'((int'(ptr) + k) % NUM_PORTS);
            else                      idx = PW'(k);
            if (!found && req[idx]) begin
                found        = 1'b1;
                win[idx]     = 1'b1;
                win_idx      = idx;
            end
        end
    end

    // Pointer only moves when a grant is actually taken, never on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (take && (PRIO_MODE == PRIO_RR) && (|req)) begin
            ptr <= (int'(win_idx) == NUM_PORTS - 1) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Block-fill / write-through arbiter in front of one pipelined memory port.
//   clk, rst_n            : clock, asynchronous active-low reset
//   miss_req, miss_addr   : per-port level fill requests and miss addresses
//   grant                 : one-hot port being filled
//   fill_we, fill_tag_we  : data / tag array strobes for the granted port
//   fill_addr, fill_data  : word address and data being written into the cache
//   busy                  : high while a fill is in progress
//   wr_req/addr/data, wr_ack : write-through store, acknowledged when issued
//   mem_en/wr/addr/wdata  : memory request side
//   mem_rdata, mem_rvalid : in-order, fixed-latency read return
module mem_fill_arbiter
    import mem_fill_arbiter_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int PRIO_MODE   = PRIO_FIXED
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    miss_req,
    input  logic [NUM_PORTS*AW-1:0] miss_addr,
    output logic [NUM_PORTS-1:0]    grant,
    output logic [NUM_PORTS-1:0]    fill_we,
    output logic [NUM_PORTS-1:0]    fill_tag_we,
    output logic [AW-1:0]           fill_addr,
    output logic [DW-1:0]           fill_data,
    output logic                    busy,
    input  logic                    wr_req,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DW-1:0]           wr_data,
    output logic                    wr_ack,
    output logic                    mem_en,
    output logic                    mem_wr,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata,
    input  logic                    mem_rvalid
);

    localparam int             BYTES     = DW / 8;
    localparam int             OFF       = clog2(BLOCK_WORDS * BYTES);
    localparam int             CW        = clog2(BLOCK_WORDS) + 1;
    localparam logic [CW-1:0]  LAST      = CW'(BLOCK_WORDS - 1);
    localparam logic [CW-1:0]  FULL      = CW'(BLOCK_WORDS);
    localparam logic [AW-1:0]  BASE_MASK = {AW{1'b1}} << OFF;

    state_t               state, state_nx;
    logic [CW-1:0]        iss_cnt, rcv_cnt;
    logic [AW-1:0]        base_q, win_addr;
    logic [NUM_PORTS-1:0] grant_q, win;
    logic                 take, rd_accept, rd_last;

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base,
                                                input logic [CW-1:0] k);
        return base + AW'(k) * AW'(BYTES);
    endfunction

    // A pending write-through blocks arbitration so the fill sees the new data.
    assign take      = (state == ST_IDLE) && !wr_req && (|miss_req);
    // Returns beyond the block length, or while idle, are dropped.
    assign rd_accept = (state == ST_FILL) && mem_rvalid && (rcv_cnt < FULL);
    assign rd_last   = rd_accept && (rcv_cnt == LAST);

    fill_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (miss_req),
        .take  (take),
        .win   (win)
    );

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win[i]) win_addr = miss_addr[i*AW +: AW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (take)    state_nx = ST_FILL;
            ST_FILL: if (rd_last) state_nx = ST_IDLE;
            default:              state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_cnt <= '0;
            rcv_cnt <= '0;
            grant_q <= '0;
        end else if (take) begin
            grant_q <= win;
            iss_cnt <= '0;
            rcv_cnt <= '0;
        end else if (state == ST_FILL) begin
            if (rd_last) begin
                grant_q <= '0;
                iss_cnt <= '0;
                rcv_cnt <= '0;
            end else begin
                if (iss_cnt < FULL) iss_cnt <= iss_cnt + 1'b1;
                if (rd_accept)      rcv_cnt <= rcv_cnt + 1'b1;
            end
        end
    end

    // Base is only observed while a grant is held, so it needs no reset.
    always_ff @(posedge clk) begin
        if (take) base_q <= win_addr & BASE_MASK;
    end

    always_comb begin
        grant       = grant_q;
        busy        = (state == ST_FILL);
        fill_we     = '0;
        fill_tag_we = '0;
        fill_addr   = '0;
        fill_data   = '0;
        wr_ack      = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state)
            ST_IDLE: begin
                if (wr_req) begin
                    mem_en    = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                    wr_ack    = 1'b1;
                end
            end
            ST_FILL: begin
                if (iss_cnt < FULL) begin
                    mem_en   = 1'b1;
                    mem_addr = word_addr(base_q, iss_cnt);
                end
                if (rd_accept) begin
                    fill_we   = grant_q;
                    fill_addr = word_addr(base_q, rcv_cnt);
                    fill_data = mem_rdata;
                    if (rd_last) fill_tag_we = grant_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
module tb_mem_fill_arbiter;

    localparam int NP  = 2;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int BW  = 8;
    localparam int LAT = 4;

    typedef struct packed {
        logic [1:0]  we;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  tag;
    } ev_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] cyc;
    } is_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     miss_req [2];
    logic [NP*AW-1:0]  miss_addr [2];
    logic              wr_req [2];
    logic [AW-1:0]     wr_addr [2];
    logic [DW-1:0]     wr_data [2];
    logic [NP-1:0]     grant [2], fill_we [2], fill_tag_we [2];
    logic [AW-1:0]     fill_addr [2], mem_addr [2];
    logic [DW-1:0]     fill_data [2], mem_wdata [2], mem_rdata [2];
    logic              busy [2], wr_ack [2], mem_en [2], mem_wr [2], mem_rvalid [2];
    logic              spur [2];

    // Memory environment: instance 0 is writable, instance 1 is read-only.
    bit   [15:0]       wmem [0:32767];
    bit                wv   [0:32767];
    logic [LAT-1:0]    pv [2] = '{default: '0};
    logic [15:0]       pd [2][LAT];
    logic [31:0]       cyc = 0;
    logic [15:0]       salt;

    ev_t               evq0[$], evq1[$];
    is_t               isq0[$], isq1[$];
    int                wrc0 = 0;

    // Reference state kept by the stimulus side
    logic [15:0]       ref_wr [logic [15:0]];
    int                rd_ev [2];
    int                rd_is [2];
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_fill_arbiter #(
            .NUM_PORTS   (NP),
            .AW          (AW),
            .DW          (DW),
            .BLOCK_WORDS (BW),
            .PRIO_MODE   (g)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .miss_req    (miss_req[g]),
            .miss_addr   (miss_addr[g]),
            .grant       (grant[g]),
            .fill_we     (fill_we[g]),
            .fill_tag_we (fill_tag_we[g]),
            .fill_addr   (fill_addr[g]),
            .fill_data   (fill_data[g]),
            .busy        (busy[g]),
            .wr_req      (wr_req[g]),
            .wr_addr     (wr_addr[g]),
            .wr_data     (wr_data[g]),
            .wr_ack      (wr_ack[g]),
            .mem_en      (mem_en[g]),
            .mem_wr      (mem_wr[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wdata   (mem_wdata[g]),
            .mem_rdata   (mem_rdata[g]),
            .mem_rvalid  (mem_rvalid[g])
        );
        assign mem_rvalid[g] = pv[g][LAT-1] | spur[g];
        assign mem_rdata[g]  = pv[g][LAT-1] ? pd[g][LAT-1] : 16'hDEAD;
    end

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a * 16'h2F1B) ^ salt ^ {a[7:0], a[15:8]};
    endfunction

    function automatic logic [15:0] rd_env(input int g, input logic [15:0] a);
        if (g == 0 && wv[a[15:1]]) return wmem[a[15:1]];
        return init_word(a);
    endfunction

    function automatic logic [15:0] exp_word(input int g, input logic [15:0] a);
        if (g == 0 && ref_wr.exists(a)) return ref_wr[a];
        return init_word(a);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            pv[g]    <= {pv[g][LAT-2:0], mem_en[g] & ~mem_wr[g]};
            pd[g][0] <= rd_env(g, mem_addr[g]);
            for (int i = 1; i < LAT; i++) pd[g][i] <= pd[g][i-1];
        end
        if (mem_en[0] && mem_wr[0]) begin
            wmem[mem_addr[0][15:1]] <= mem_wdata[0];
            wv[mem_addr[0][15:1]]   <= 1'b1;
        end
    end

    always @(negedge clk) begin
        ev_t e;
        is_t s;
        if (fill_we[0] != 0 || fill_tag_we[0] != 0) begin
            e = {fill_we[0], fill_addr[0], fill_data[0], fill_tag_we[0]};
            evq0.push_back(e);
        end
        if (fill_we[1] != 0 || fill_tag_we[1] != 0) begin
            e = {fill_we[1], fill_addr[1], fill_data[1], fill_tag_we[1]};
            evq1.push_back(e);
        end
        if (mem_en[0] && !mem_wr[0]) begin s = {mem_addr[0], cyc}; isq0.push_back(s); end
        if (mem_en[1] && !mem_wr[1]) begin s = {mem_addr[1], cyc}; isq1.push_back(s); end
        if (mem_en[0] && mem_wr[0]) wrc0 = wrc0 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int g, input string nm);
        chk(nm, {grant[g], fill_we[g], fill_tag_we[g], fill_addr[g], fill_data[g], busy[g],
                 wr_ack[g], mem_en[g], mem_wr[g], mem_addr[g], mem_wdata[g]}, 128'd0);
    endtask

    // Runs cycles while filling until the tag strobe; then steps into the
    // following IDLE cycle, drops the requested miss bits and checks idle.
    task automatic wait_tag(input int g, input logic [1:0] drop, output logic [1:0] tag_port);
        bit seen;
        seen     = 1'b0;
        tag_port = '0;
        for (int n = 0; n < 60 && !seen; n++) begin
            tick();
            #1;
            chk("fill_busy_noack", {busy[g], wr_ack[g]}, {1'b1, 1'b0});
            if (fill_tag_we[g] != 0) begin
                seen     = 1'b1;
                tag_port = fill_tag_we[g];
                tick();
                miss_req[g] = miss_req[g] & ~drop;
                #1;
                chk("idle_after_tag", {busy[g], grant[g]}, 3'b000);
            end
        end
        chk("tag_seen", seen, 1'b1);
    endtask

    task automatic check_fill(input int g, input logic [1:0] p, input logic [15:0] base, input string nm);
        int ne, ni;
        ev_t e, x;
        is_t s, s0;
        ne = (g == 0 ? evq0.size() : evq1.size()) - rd_ev[g];
        ni = (g == 0 ? isq0.size() : isq1.size()) - rd_is[g];
        chk({nm, "_nwords"}, ne, BW);
        chk({nm, "_nissue"}, ni, BW);
        if (ne >= BW && ni >= BW) begin
            s0 = (g == 0) ? isq0[rd_is[g]] : isq1[rd_is[g]];
            for (int k = 0; k < BW; k++) begin
                logic [15:0] a;
                a = base + 16'(2 * k);
                e = (g == 0) ? evq0[rd_ev[g] + k] : evq1[rd_ev[g] + k];
                x = {p, a, exp_word(g, a), (k == BW - 1) ? p : 2'b00};
                chk({nm, "_word"}, e, x);
                s = (g == 0) ? isq0[rd_is[g] + k] : isq1[rd_is[g] + k];
                chk({nm, "_issue"}, s, {a, s0.cyc + 32'(k)});
            end
        end
        rd_ev[g] += ne;
        rd_is[g] += ni;
    endtask

    initial begin
        logic [1:0]  tp, exp_oh, rq;
        logic [15:0] a0, a1, wa, wa2, wd, wd2, b;
        int          ptr, w, n0, wrc_start;
        bit          found;

        salt = 16'($urandom);
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            miss_req[g] = '0; miss_addr[g] = '0; wr_req[g] = 1'b0;
            wr_addr[g] = '0; wr_data[g] = '0; spur[g] = 1'b0;
            rd_ev[g] = 0; rd_is[g] = 0;
        end
        repeat (3) tick();
        #1;
        chk_zero(0, "reset_fixed");
        chk_zero(1, "reset_rr");
        rst_n = 1'b1;
        tick();

        // Single fill, port 1, address 0x1234
        miss_addr[0] = {16'h1234, 16'h0000};
        miss_req[0]  = 2'b10;
        tick(); #1;
        chk("single_grant", {busy[0], grant[0]}, 3'b110);
        wait_tag(0, 2'b10, tp);
        chk("single_tag_port", tp, 2'b10);
        check_fill(0, 2'b10, 16'h1230, "single");

        // Simultaneous requests, fixed priority
        a0 = 16'($urandom); a1 = 16'($urandom);
        miss_addr[0] = {a1, a0};
        miss_req[0]  = 2'b11;
        tick(); #1;
        chk("fixed_first_grant", grant[0], 2'b01);
        wait_tag(0, 2'b01, tp);
        chk("fixed_first_tag", tp, 2'b01);
        check_fill(0, 2'b01, a0 & 16'hFFF0, "fixed_p0");
        tick(); #1;
        chk("fixed_second_grant", {busy[0], grant[0]}, 3'b110);
        wait_tag(0, 2'b10, tp);
        chk("fixed_second_tag", tp, 2'b10);
        check_fill(0, 2'b10, a1 & 16'hFFF0, "fixed_p1");

        // Round-robin, both ports requesting for four fills
        a0 = 16'($urandom); a1 = 16'($urandom);
        miss_addr[1] = {a1, a0};
        rq = 2'b11;
        miss_req[1] = rq;
        ptr = 0;
        for (int f = 0; f < 4; f++) begin
            found = 1'b0; w = 0;
            for (int k = 0; k < NP; k++) begin
                if (!found && rq[(ptr + k) % NP]) begin found = 1'b1; w = (ptr + k) % NP; end
            end
            ptr = (w + 1) % NP;
            exp_oh = 2'(1 << w);
            b = miss_addr[1][w*AW +: AW] & 16'hFFF0;
            wait_tag(1, (f == 3) ? 2'b11 : 2'b00, tp);
            chk("rr_order", tp, exp_oh);
            check_fill(1, exp_oh, b, "rr");
        end

        // Write-through in the same cycle as a miss, then held during a fill
        wrc_start = wrc0;
        a0 = 16'($urandom);
        b  = a0 & 16'hFFF0;
        wa = b + 16'(2 * $urandom_range(0, BW - 1));
        wd = 16'($urandom);
        miss_addr[0] = {16'h0000, a0};
        miss_req[0]  = 2'b01;
        wr_req[0] = 1'b1; wr_addr[0] = wa; wr_data[0] = wd;
        #1;
        chk("wr_issue", {wr_ack[0], mem_en[0], mem_wr[0], mem_addr[0], mem_wdata[0], busy[0]},
            {1'b1, 1'b1, 1'b1, wa, wd, 1'b0});
        ref_wr[wa] = wd;
        tick();
        wr_req[0] = 1'b0;
        #1;
        chk("wr_then_arb", {wr_ack[0], busy[0], grant[0]}, 4'b0000);
        tick(); #1;
        chk("wr_fill_start", {busy[0], grant[0]}, 3'b101);
        tick();
        wa2 = 16'($urandom) & 16'hFFFE;
        wd2 = 16'($urandom);
        wr_req[0] = 1'b1; wr_addr[0] = wa2; wr_data[0] = wd2;
        wait_tag(0, 2'b01, tp);
        chk("wr_fill_tag", tp, 2'b01);
        chk("held_wr_issue", {wr_ack[0], mem_en[0], mem_wr[0], mem_addr[0], mem_wdata[0]},
            {1'b1, 1'b1, 1'b1, wa2, wd2});
        check_fill(0, 2'b01, b, "wr_fill");
        ref_wr[wa2] = wd2;
        tick();
        wr_req[0] = 1'b0;
        #1;
        chk("held_wr_done", {wr_ack[0], busy[0]}, 2'b00);
        chk("wr_count", wrc0 - wrc_start, 2);

        // Reset after three received words
        a1 = 16'($urandom);
        miss_addr[0] = {a1, 16'h0000};
        miss_req[0]  = 2'b10;
        n0 = rd_ev[0];
        for (int n = 0; n < 40 && (evq0.size() - n0) < 3; n++) tick();
        chk("pre_reset_words", evq0.size() - n0, 3);
        rst_n = 1'b0;
        miss_req[0] = 2'b00;
        #1;
        chk_zero(0, "mid_fill_reset");
        tick(); tick();
        rst_n = 1'b1;
        repeat (8) tick();
        #1;
        chk("late_rvalid_ignored", evq0.size() - n0, 3);
        chk("post_reset_idle", {busy[0], grant[0]}, 3'b000);
        for (int k = n0; k < evq0.size(); k++) chk("no_partial_tag", evq0[k].tag, 2'b00);
        rd_ev[0] = evq0.size();
        rd_is[0] = isq0.size();
        a0 = 16'($urandom);
        miss_addr[0] = {16'h0000, a0};
        miss_req[0]  = 2'b01;
        wait_tag(0, 2'b01, tp);
        chk("post_reset_tag", tp, 2'b01);
        check_fill(0, 2'b01, a0 & 16'hFFF0, "post_reset");

        // Spurious read return while idle
        n0 = evq0.size();
        spur[0] = 1'b1;
        #1;
        chk("spur_no_strobe", {fill_we[0], fill_tag_we[0], busy[0], grant[0]}, 7'd0);
        tick();
        spur[0] = 1'b0;
        #1;
        chk("spur_state", {busy[0], grant[0], 32'(evq0.size() - n0)}, 35'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
